// File: rtl/demux_n_collector_pkg.sv
// Shared types and defaults for the 1:N bit-slot demux collector.
package demux_pkg;

  typedef enum logic {S_COLLECT, S_HOLD} collector_state_t;

  localparam int N_DEFAULT     = 5;
  localparam int SEL_W_DEFAULT = $clog2(N_DEFAULT);

endpackage

// File: rtl/demux_n_collector_if.sv
// Beat-in / frame-out handshake bundle for the demux collector.
interface demux_n_collector_if
  import demux_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int SEL_W = $clog2(N)
);

  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] in_sel;
  logic             in_bit;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_frame;
  logic             sel_err;
  logic             dup_warn;

  // Source of beats and consumer of frames.
  modport master (
    output in_valid, in_sel, in_bit, out_ready,
    input  in_ready, out_valid, out_frame, sel_err, dup_warn
  );

  // The collector itself.
  modport slave (
    input  in_valid, in_sel, in_bit, out_ready,
    output in_ready, out_valid, out_frame, sel_err, dup_warn
  );

endinterface

// File: rtl/demux_n_collector_decoder.sv
// Select-to-one-hot decoder; codes at or above N decode to all-zero and raise out_of_range.
module decoder_n
  import demux_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [SEL_W-1:0] sel,
  output logic [N-1:0]     onehot,
  output logic             out_of_range
);

  always_comb begin
    for (int i = 0; i < N; i++) begin
      onehot[i] = (sel == SEL_W'(i));
    end
  end

  // An in-range code always lights exactly one bit, so no bit means sel >= N.
  assign out_of_range = ~|onehot;

endmodule

// File: rtl/demux_n_collector.sv
// Routes addressed single-bit beats into an N-bit frame and presents the frame
// on a valid/ready port once every slot has been written.
module demux_n_collector
  import demux_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int SEL_W = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  demux_n_collector_if.slave  bus
);

  collector_state_t state_q, state_d;
  logic [N-1:0]     frame_q, frame_d;
  logic [N-1:0]     mask_q,  mask_d;
  logic             sel_err_q, sel_err_d;
  logic             dup_warn_q, dup_warn_d;

  logic [N-1:0]     onehot;
  logic             out_of_range;
  logic             accept;

  decoder_n #(.N(N), .SEL_W(SEL_W)) u_decoder (
    .sel          (bus.in_sel),
    .onehot       (onehot),
    .out_of_range (out_of_range)
  );

  assign accept = bus.in_valid && (state_q == S_COLLECT);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    frame_d    = frame_q;
    mask_d     = mask_q;
    sel_err_d  = 1'b0;
    dup_warn_d = 1'b0;

    unique case (state_q)
      S_COLLECT: begin
        if (accept) begin
          if (out_of_range) begin
            sel_err_d = 1'b1;
          end else begin
            dup_warn_d = |(mask_q & onehot);
            frame_d    = (frame_q & ~onehot) | (onehot & {N{bus.in_bit}});
            mask_d     = mask_q | onehot;
            if (&mask_d) state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // Handoff cycle clears the frame; no beat is taken because in_ready is low.
        if (bus.out_ready) begin
          frame_d = '0;
          mask_d  = '0;
          state_d = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignment so all flops update from pre-edge values.
    if (rst) begin
      state_q    <= S_COLLECT;
      frame_q    <= '0;
      mask_q     <= '0;
      sel_err_q  <= 1'b0;
      dup_warn_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      mask_q     <= mask_d;
      sel_err_q  <= sel_err_d;
      dup_warn_q <= dup_warn_d;
    end
  end

  assign bus.in_ready  = (state_q == S_COLLECT);
  assign bus.out_valid = (state_q == S_HOLD);
  assign bus.out_frame = (state_q == S_HOLD) ? frame_q : '0;
  assign bus.sel_err   = sel_err_q;
  assign bus.dup_warn  = dup_warn_q;

endmodule
